// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer slice.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_UPDATE = 2'd2,
    S_TRAP   = 2'd3
  } state_t;

  // BrOP[4:3] classes: 00 no branch, 01 conditional branch, 1x jump
  localparam logic [1:0]  BROP_NONE     = 2'b00;
  localparam logic [1:0]  BROP_COND     = 2'b01;
  localparam int unsigned BROP_JUMP_BIT = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_cond_branch(input logic [1:0] brop_cls);
    return brop_cls == BROP_COND;
  endfunction

endpackage

// File: rtl/pc_stat_counters.sv
// Retired conditional-branch and taken-branch statistics counters.
module pc_stat_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (en) begin
      branch_cnt <= branch_cnt + 1'b1;
      if (taken) taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute/update PC controller with misaligned-target trap.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned    CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             stall,
  input  logic [4:0]       br_op,
  input  logic             next_pc_src,
  input  logic [XLEN-1:0]  br_target,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             redirect,
  output logic             trap,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t          state;
  logic            taken_q;
  logic [XLEN-1:0] target_q;
  logic [1:0]      brop_cls_q;
  logic            misaligned;
  logic            update_ok;
  logic            unused_brop_low;

  // Only the class bits of BrOP matter here; the low bits select the compare.
  assign unused_brop_low = ^br_op[2:0];

  assign pc_plus4    = pc + XLEN'(4);
  assign imem_addr   = pc;
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_EXEC);
  assign misaligned  = taken_q && (target_q[1:0] != 2'b00);
  assign update_ok   = (state == S_UPDATE) && !misaligned;
  assign redirect    = update_ok && taken_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      instr      <= '0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      brop_cls_q <= BROP_NONE;
      trap       <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall && exec_done) begin
            taken_q    <= next_pc_src;
            target_q   <= br_target;
            brop_cls_q <= br_op[BROP_JUMP_BIT:BROP_JUMP_BIT-1];
            state      <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (misaligned) begin
            trap  <= 1'b1;
            state <= S_TRAP;
          end else begin
            pc    <= taken_q ? target_q : pc_plus4;
            state <= S_FETCH;
          end
        end
        S_TRAP: trap <= 1'b1;
      endcase
    end
  end

  pc_stat_counters #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .en        (update_ok && is_cond_branch(brop_cls_q)),
    .taken     (taken_q),
    .branch_cnt(branch_cnt),
    .taken_cnt (taken_cnt)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        stall;
  logic [4:0]  br_op;
  logic        next_pc_src;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        trap;
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned fetch_cycles;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .CNT_W   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .stall      (stall),
    .br_op      (br_op),
    .next_pc_src(next_pc_src),
    .br_target  (br_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .redirect   (redirect),
    .trap       (trap),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fetch with immediate ready, execute with immediate done; returns in UPDATE.
  task automatic run_to_update(input logic [31:0] rdata, input logic [4:0] op,
                               input logic nps, input logic [31:0] tgt);
    imem_ready = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ready  = 1'b0;
    exec_done   = 1'b1;
    br_op       = op;
    next_pc_src = nps;
    br_target   = tgt;
    tick();
    exec_done   = 1'b0;
    br_op       = 5'b0;
    next_pc_src = 1'b0;
    br_target   = 32'h0;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
    stall = 1'b0; br_op = 5'b0; next_pc_src = 1'b0; br_target = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_bcnt", branch_cnt, 32'd0);
    chk("rst_tcnt", taken_cnt, 32'd0);

    // plain instruction: two wait cycles, then ready
    fetch_cycles = 0;
    for (int i = 0; i < 2; i++) begin
      if (imem_req) fetch_cycles++;
      tick();
    end
    chk("t1_addr", imem_addr, 32'h0);
    if (imem_req) fetch_cycles++;
    imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ready = 1'b0;
    chk("t1_fetch_cycles", fetch_cycles, 32'd3);
    chk("t1_instr", instr, 32'h13);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_req_exec", 32'(imem_req), 32'd0);
    exec_done = 1'b1; next_pc_src = 1'b0; br_op = 5'b0;
    tick();
    exec_done = 1'b0;
    chk("t1_upd_valid", 32'(instr_valid), 32'd0);
    chk("t1_upd_redirect", 32'(redirect), 32'd0);
    tick();
    chk("t1_pc", pc, 32'h4);
    chk("t1_redirect_after", 32'(redirect), 32'd0);

    // BEQ taken to 0x40
    run_to_update(32'h0000_0063, 5'b01000, 1'b1, 32'h40);
    chk("beq_redirect", 32'(redirect), 32'd1);
    chk("beq_pc_hold", pc, 32'h4);
    tick();
    chk("beq_pc", pc, 32'h40);
    chk("beq_redirect_off", 32'(redirect), 32'd0);
    chk("beq_bcnt", branch_cnt, 32'd1);
    chk("beq_tcnt", taken_cnt, 32'd1);

    // BNE not taken at 0x40
    run_to_update(32'h0000_1063, 5'b01001, 1'b0, 32'h80);
    chk("bne_redirect", 32'(redirect), 32'd0);
    tick();
    chk("bne_pc", pc, 32'h44);
    chk("bne_bcnt", branch_cnt, 32'd2);
    chk("bne_tcnt", taken_cnt, 32'd1);

    // asynchronous reset mid-FETCH at pc=0x44
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_bcnt", branch_cnt, 32'd0);
    chk("arst_tcnt", taken_cnt, 32'd0);
    tick();
    rst = 1'b0;
    chk("arst_req", 32'(imem_req), 32'd1);
    chk("arst_addr", imem_addr, 32'h0);

    // stall holds EXEC even with exec_done
    imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
    tick();
    imem_ready = 1'b0;
    stall = 1'b1; exec_done = 1'b1; br_op = 5'b0; next_pc_src = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", pc, 32'h0);
    end
    stall = 1'b0;
    tick();
    exec_done = 1'b0;
    chk("stall_upd_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("stall_pc_after", pc, 32'h4);

    // jump to 0xFFFFFFFC, then not-taken BNE wraps pc to 0
    run_to_update(32'h0000_006F, 5'b10000, 1'b1, 32'hFFFF_FFFC);
    chk("jmp_redirect", 32'(redirect), 32'd1);
    tick();
    chk("jmp_pc", pc, 32'hFFFF_FFFC);
    chk("jmp_plus4", pc_plus4, 32'h0);
    chk("jmp_bcnt", branch_cnt, 32'd0);
    run_to_update(32'h0000_1063, 5'b01001, 1'b0, 32'h10);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_bcnt", branch_cnt, 32'd1);
    chk("wrap_tcnt", taken_cnt, 32'd0);

    // JAL to misaligned 0x102 traps
    run_to_update(32'h0000_006F, 5'b10000, 1'b1, 32'h102);
    chk("jal_redirect", 32'(redirect), 32'd0);
    tick();
    chk("jal_trap", 32'(trap), 32'd1);
    chk("jal_pc", pc, 32'h0);
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("trap_req", 32'(imem_req), 32'd0);
      chk("trap_valid", 32'(instr_valid), 32'd0);
      chk("trap_sticky", 32'(trap), 32'd1);
      chk("trap_pc", pc, 32'h0);
    end
    imem_ready = 1'b0;
    chk("trap_bcnt", branch_cnt, 32'd1);
    chk("trap_tcnt", taken_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle program-counter controller that sequences instruction fetch and execute around the branch unit. It owns the PC register and drives instruction-memory requests with a ready handshake. It presents each instruction to the datapath and waits for completion. It then selects PC+4 or the branch/jump target from the branch unit's NextPCSrc decision. It also traps on misaligned targets and keeps branch statistics counters.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  XLEN  fetch address (equals pc)
imem_ready  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
instr  out  32  latched instruction to the decoder
instr_valid  out  1  instr is valid and executing
exec_done  in  1  datapath finished the current instruction
stall  in  1  hold the sequencer in EXEC
br_op  in  5  BrOP of the current instruction (same encoding as the branch unit)
next_pc_src  in  1  NextPCSrc from the branch unit
br_target  in  XLEN  branch/jump target from the ALU
pc  out  XLEN  current PC
pc_plus4  out  XLEN  pc + 4, modulo 2^XLEN
redirect  out  1  one-cycle pulse when a taken branch or jump updates the PC
trap  out  1  sticky misaligned-target trap
branch_cnt  out  CNT_W  count of conditional branches retired
taken_cnt  out  CNT_W  count of taken conditional branches

Behaviour:
- Reset (async, any state): state=FETCH, pc=RESET_PC, instr=0, all flags and counters 0.
- Outputs after reset: imem_req=1 once FETCH is entered; instr_valid=0, redirect=0, trap=0.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1: instr<=imem_rdata, go to EXEC.
  - Otherwise hold. No timeout.
  - imem_ready while not in FETCH is ignored.
- EXEC:
  - instr_valid=1, imem_req=0.
  - stall=1 has priority over exec_done. Hold; no PC change.
  - exec_done=1 and stall=0: sample next_pc_src, br_target and br_op in the same cycle, then go to UPDATE.
- UPDATE (single cycle):
  - instr_valid=0.
  - taken = next_pc_src (the branch unit already forces 0 for BrOP[4:3]=00 and 1 for BrOP[4]=1).
  - taken=1 and br_target[1:0]!=00: go to TRAP, pc unchanged, trap<=1.
  - taken=1 and target aligned: pc<=br_target, redirect pulses high for this cycle.
  - taken=0: pc<=pc_plus4.
  - Then go to FETCH.
- Counters, only when leaving UPDATE without a trap:
  - branch_cnt increments when br_op[4:3]=01 (conditional branch).
  - taken_cnt increments when that branch was also taken.
  - Jumps (br_op[4]=1) are not counted.
  - Counters wrap at 2^CNT_W.
- TRAP: terminal. imem_req=0, instr_valid=0, trap=1. Only rst exits.
- PC arithmetic: pc+4 wraps silently (32'hFFFF_FFFC -> 0). The aligned-target check applies only to taken targets.
- Latency: minimum 3 cycles per instruction (FETCH with immediate ready, EXEC with immediate done, UPDATE).
- Reset asserted mid-fetch or mid-exec: discard instr, restart at RESET_PC. The imem handshake is not completed.
- State encoding: FETCH=2'd0, EXEC=2'd1, UPDATE=2'd2, TRAP=2'd3.

Decomposition:
- Shared package/include:
  - state encodings;
  - BrOP class masks: BROP_NONE 2'b00, BROP_COND 2'b01, BROP_JUMP bit4;
  - RESET_PC default.
- One natural sub-module: pc_stat_counters, holding branch_cnt and taken_cnt with an enable and taken input.
- FSM, PC register and alignment check stay in pc_sequencer.

Test Plan:
- Reset, then imem_ready=1 after 2 waits, rdata=32'h00000013, exec_done next cycle, next_pc_src=0 -> imem_addr 0, instr=32'h13, pc becomes 4, redirect stays 0, 3 FETCH cycles observed.
- BEQ, br_op=5'b01000, next_pc_src=1, br_target=32'h40 -> pc=32'h40, redirect one-cycle pulse, branch_cnt=1, taken_cnt=1.
- BNE not taken, br_op=5'b01001, next_pc_src=0 at pc=32'h40 -> pc=32'h44, branch_cnt=2, taken_cnt=1.
- JAL, br_op=5'b10000, target 32'h102 -> TRAP, trap=1, pc holds, imem_req stays 0 for 10 cycles, counters unchanged.
- stall=1 with exec_done=1 for 4 cycles, then stall=0 -> PC updates only after release, instr_valid high throughout the stall.
- rst asserted mid-FETCH with pc=32'h44 -> pc=0 immediately (asynchronous), counters 0, fetch restarts at 0. Separately, pc=32'hFFFFFFFC not taken -> pc=0.
